// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_RESP = 2'd1,
    D_RESP  = 2'd2
  } state_t;

  localparam logic [2:0] FUNCT3_LW = 3'b010;

  // What the response registers capture at the grant edge.
  typedef struct packed {
    logic if_cap;
    logic d_cap;
    logic d_store;
  } resp_t;

endpackage

// File: rtl/mem_arbiter_arb_grant.sv
// Two-requester fixed-priority grant: data wins unless if_first hands priority to fetch.
module arb_grant (
  input  logic if_req,
  input  logic d_req,
  input  logic if_first,
  output logic if_gnt_c,
  output logic d_gnt_c
);

  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (if_req && (if_first || !d_req)) begin
      if_gnt_c = 1'b1;
    end else if (d_req) begin
      d_gnt_c = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch and a data port onto one single-cycle memory.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH   = 32,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  if (MAX_WAIT < 1) begin : g_max_wait_chk
    $error("mem_arbiter: MAX_WAIT must be at least 1");
  end

  state_t state_q, state_d;
  resp_t  resp;
  logic   if_first;

  // Reset masks requests so nothing is granted or driven to memory.
  arb_grant u_arb_grant (
    .if_req   (if_req_i & ~rst),
    .d_req    (d_req_i & ~rst),
    .if_first (if_first),
    .if_gnt_c (if_gnt_o),
    .d_gnt_c  (d_gnt_o)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts consecutive denied fetch cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (if_gnt_o) begin
      wait_cnt <= '0;
    end else if (if_req_i && (wait_cnt != CNT_W'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign if_first = (wait_cnt == CNT_W'(MAX_WAIT));
`else
  assign if_first = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory-side drive follow whichever requester was granted.
  always_comb begin
    state_d        = IDLE;
    resp           = '0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_funct3_o   = 3'b000;
    if (if_gnt_o) begin
      state_d       = IF_RESP;
      resp.if_cap   = 1'b1;
      mem_addr_o    = if_addr_i;
      mem_read_en_o = 1'b1;
      mem_funct3_o  = FUNCT3_LW;
    end else if (d_gnt_o) begin
      state_d        = D_RESP;
      resp.d_cap     = 1'b1;
      resp.d_store   = d_we_i;
      mem_addr_o     = d_addr_i;
      mem_data_o     = d_wdata_i;
      mem_read_en_o  = ~d_we_i;
      mem_write_en_o = d_we_i;
      mem_funct3_o   = d_funct3_i;
    end
  end

  // Read data is sampled at the grant edge; stores acknowledge with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      if (resp.if_cap) begin
        if_rdata_o <= mem_data_i;
      end
      if (resp.d_cap) begin
        d_rdata_o <= resp.d_store ? '0 : mem_data_i;
      end
    end
  end

  assign if_rvalid_o = (state_q == IF_RESP) & ~rst;
  assign d_rvalid_o  = (state_q == D_RESP) & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [2:0]    d_funct3_i = 3'b000;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_read_en_o, mem_write_en_o;
  logic [2:0]    mem_funct3_o;
  logic [DW-1:0] mem_data_i = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: the response expected after the next edge, and fetch wait length.
  logic          m_if_rvalid = 1'b0, m_d_rvalid = 1'b0;
  logic [DW-1:0] m_if_rdata = '0, m_d_rdata = '0;
  int            m_wait = 0;
  logic          m_gi = 1'b0, m_gd = 1'b0;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_funct3_i(d_funct3_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
    .mem_funct3_o(mem_funct3_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model past the posedge.
  task automatic step(input logic r, input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dwe, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd, input logic [2:0] f3,
                      input logic [DW-1:0] md);
    logic gi, gd, ere, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [2:0] ef;
    logic fetch_prio;
    @(negedge clk);
    rst = r; if_req_i = ir; if_addr_i = ia; d_req_i = dr; d_we_i = dwe;
    d_addr_i = da; d_wdata_i = dwd; d_funct3_i = f3; mem_data_i = md;
    #1;
`ifdef ARB_STARVE_GUARD_EN
    fetch_prio = (m_wait >= MW);
`else
    fetch_prio = 1'b0;
`endif
    gi = !r && ir && (!dr || fetch_prio);
    gd = !r && dr && !gi;
    ea = gi ? ia : (gd ? da : '0);
    ed = gd ? dwd : '0;
    ere = gi || (gd && !dwe);
    ewe = gd && dwe;
    ef = gi ? 3'b010 : (gd ? f3 : 3'b000);
    check("if_gnt", 64'(if_gnt_o), 64'(gi));
    check("d_gnt", 64'(d_gnt_o), 64'(gd));
    check("mem_addr", 64'(mem_addr_o), 64'(ea));
    check("mem_data", 64'(mem_data_o), 64'(ed));
    check("mem_re", 64'(mem_read_en_o), 64'(ere));
    check("mem_we", 64'(mem_write_en_o), 64'(ewe));
    check("mem_f3", 64'(mem_funct3_o), 64'(ef));
    check("if_rvalid", 64'(if_rvalid_o), 64'(m_if_rvalid && !r));
    check("if_rdata", 64'(if_rdata_o), 64'(m_if_rdata));
    check("d_rvalid", 64'(d_rvalid_o), 64'(m_d_rvalid && !r));
    check("d_rdata", 64'(d_rdata_o), 64'(m_d_rdata));
    m_gi = gi;
    m_gd = gd;
    if (r) begin
      m_if_rvalid = 1'b0; m_d_rvalid = 1'b0;
      m_if_rdata = '0; m_d_rdata = '0; m_wait = 0;
    end else begin
      m_if_rvalid = gi;
      m_d_rvalid = gd;
      if (gi) m_if_rdata = md;
      if (gd) m_d_rdata = dwe ? '0 : md;
      if (gi) m_wait = 0;
      else if (ir && m_wait < MW) m_wait++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000, '0);
  endtask

  initial begin
    logic          ir, dr, dwe;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dwd;
    logic [2:0]    f3;

    // Reset with requests present: nothing granted, everything zero.
    step(1'b1, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h5678, 32'hFFFF, 3'b010, 32'hAAAA);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 3'b000, '0);
    check("rst_if_rdata", 64'(if_rdata_o), 64'h0);
    check("rst_mem_re", 64'(mem_read_en_o), 64'h0);

    // Lone fetch.
    step(1'b0, 1'b1, 32'h0100_0000, 1'b0, 1'b0, '0, '0, 3'b000, 32'h0000_0013);
    check("fetch_gnt", 64'(if_gnt_o), 64'h1);
    idle();
    check("fetch_rvalid", 64'(if_rvalid_o), 64'h1);
    check("fetch_rdata", 64'(if_rdata_o), 64'h13);

    // Contended fetch and load: data first, fetch next.
    step(1'b0, 1'b1, 32'h0100_0004, 1'b1, 1'b0, 32'h0200_0004, 32'h0, 3'b001, 32'hCAFE_0001);
    check("contend_dgnt", 64'(d_gnt_o), 64'h1);
    check("contend_f3", 64'(mem_funct3_o), 64'h1);
    step(1'b0, 1'b1, 32'h0100_0004, 1'b0, 1'b0, '0, '0, 3'b000, 32'hCAFE_0002);
    check("contend_ignt", 64'(if_gnt_o), 64'h1);
    check("contend_drdata", 64'(d_rdata_o), 64'hCAFE_0001);
    idle();
    check("contend_irdata", 64'(if_rdata_o), 64'hCAFE_0002);

    // Store acknowledge carries zero data.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h0300_0000, 32'hDEAD_BEEF, 3'b000, 32'h5555_5555);
    check("store_we", 64'(mem_write_en_o), 64'h1);
    check("store_data", 64'(mem_data_o), 64'hDEAD_BEEF);
    idle();
    check("store_rvalid", 64'(d_rvalid_o), 64'h1);
    check("store_rdata", 64'(d_rdata_o), 64'h0);

    // Reset landing on a load's grant cycle cancels its response.
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h0400_0000, '0, 3'b010, 32'h7777_7777);
    idle();
    check("rst_cancel_rvalid", 64'(d_rvalid_o), 64'h0);

`ifdef ARB_STARVE_GUARD_EN
    // Data hogging: fetch forced through on the fifth contended cycle.
    for (int c = 1; c <= 6; c++) begin
      step(1'b0, c <= 5, 32'h0100_0100, 1'b1, 1'b0, 32'h0200_0000 + 32'(c), '0, 3'b010, 32'(c));
      check("guard_ignt", 64'(if_gnt_o), 64'(c == 5));
      check("guard_dgnt", 64'(d_gnt_o), 64'(c != 5));
    end
    idle();
`endif

    // Randomized traffic; pending requests usually stay up until granted.
    ir = 1'b0; dr = 1'b0; dwe = 1'b0; ia = '0; da = '0; dwd = '0; f3 = '0;
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r = ($urandom_range(0, 63) == 0);
      if (!(ir && !m_gi && $urandom_range(0, 7) != 0)) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = $urandom;
      end
      if (!(dr && !m_gd && $urandom_range(0, 7) != 0)) begin
        dr = ($urandom_range(0, 2) != 0);
        dwe = $urandom_range(0, 1) == 1;
        da = $urandom;
        dwd = $urandom;
        f3 = 3'($urandom_range(0, 7));
      end
      step(r, ir, ia, dr, dwe, da, dwd, f3, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
